// File: rtl/irq_dispatcher.sv
// Priority interrupt dispatcher: arbitrates synchronized level requests, presents irq/vector,
// emits a one-cycle clear address on acknowledge and sequences service, EOI and drain.
// Optional per-source masking is enabled with the IRQ_DISPATCHER_MASK_EN macro.
module irq_dispatcher #(
  parameter int unsigned NUM_SRC      = 4,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter logic [31:0] ACK_BASE     = 32'h0000_0400,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] int_req,
  output logic               irq,
  output logic [31:0]        irq_vector,
  input  logic               cpu_ack,
  input  logic               eoi,
  output logic [31:0]        access_addr,
  output logic [3:0]         active_id,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 2);

  typedef enum logic [2:0] {StIdle, StPend, StAck, StService, StDrain} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] req_meta_q, req_s_q;
  logic [NUM_SRC-1:0] masked, eligible;
  logic [3:0]         pick;
  logic [3:0]         sel_q, sel_d;
  logic               irq_q, irq_d;
  logic [31:0]        vec_q, vec_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         id_q, id_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

`ifdef IRQ_DISPATCHER_MASK_EN
  logic [NUM_SRC-1:0] mask_q, mask_d;

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign masked = mask_q;
`else
  logic unused_mask;
  assign unused_mask = ^{mask_we, mask_wdata};
  assign masked      = '0;
`endif

  assign eligible = req_s_q & ~masked;

  // Lowest set index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    pick = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          sel_d   = pick;
          irq_d   = 1'b1;
          vec_d   = VEC_BASE + {26'b0, pick, 2'b00};
          state_d = StPend;
        end
      end
      StPend: begin
        if (cpu_ack) begin
          irq_d   = 1'b0;
          addr_d  = ACK_BASE + {26'b0, sel_q, 2'b00};
          id_d    = sel_q;
          state_d = StAck;
        end
      end
      StAck: begin
        addr_d  = '0;
        state_d = StService;
      end
      StService: begin
        if (eoi) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = CntW'(DRAIN_CYCLES);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Stay exactly DRAIN_CYCLES cycles so the cleared source can drop its request.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_meta_q <= '0;
      req_s_q    <= '0;
      state_q    <= StIdle;
      sel_q      <= '0;
      irq_q      <= 1'b0;
      vec_q      <= '0;
      addr_q     <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
    end else begin
      req_meta_q <= int_req;
      req_s_q    <= req_meta_q;
      state_q    <= state_d;
      sel_q      <= sel_d;
      irq_q      <= irq_d;
      vec_q      <= vec_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign irq         = irq_q;
  assign irq_vector  = vec_q;
  assign access_addr = addr_q;
  assign active_id   = id_q;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Self-checking bench for irq_dispatcher: priority table, scoreboard of expected services,
// and hand sequences for latency, non-preemption, eoi/ack corners, async reset and masking.
module tb_irq_dispatcher;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  int_req;
  logic        irq;
  logic [31:0] irq_vector;
  logic        cpu_ack;
  logic        eoi;
  logic [31:0] access_addr;
  logic [3:0]  active_id;
  logic        mask_we;
  logic [3:0]  mask_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] vec;
    logic [31:0] ack;
    logic [3:0]  id;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] first_vec;
    int unsigned n_serve;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];

  always #5 clock = ~clock;

  irq_dispatcher #(
    .NUM_SRC     (4),
    .VEC_BASE    (32'h0000_0100),
    .ACK_BASE    (32'h0000_0400),
    .DRAIN_CYCLES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .int_req    (int_req),
    .irq        (irq),
    .irq_vector (irq_vector),
    .cpu_ack    (cpu_ack),
    .eoi        (eoi),
    .access_addr(access_addr),
    .active_id  (active_id),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int unsigned id);
    exp_t e;
    e.vec = 32'h0000_0100 + 32'(id) * 32'd4;
    e.ack = 32'h0000_0400 + 32'(id) * 32'd4;
    e.id  = 4'(id);
    return e;
  endfunction

  task automatic push_pattern(input logic [3:0] p);
    for (int i = 0; i < 4; i++) begin
      if (p[i]) sb.push_back(mk(i));
    end
  endtask

  task automatic wait_irq();
    int n = 0;
    while (irq !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("irq_wait", {31'b0, irq}, 32'd1);
  endtask

  task automatic finish_service(input exp_t e);
    cpu_ack = 1'b1;
    @(negedge clock);
    cpu_ack = 1'b0;
    check("ack_addr", access_addr, e.ack);
    check("active_id", {28'b0, active_id}, {28'b0, e.id});
    check("irq_drop", {31'b0, irq}, 32'd0);
    int_req[e.id] = 1'b0;
    @(negedge clock);
    check("addr_idle", access_addr, 32'd0);
    repeat (2) @(negedge clock);
    eoi = 1'b1;
    @(negedge clock);
    eoi = 1'b0;
    check("drain_hold0", {31'b0, irq}, 32'd0);
    @(negedge clock);
    check("drain_hold1", {31'b0, irq}, 32'd0);
  endtask

  task automatic serve_one(output logic [31:0] got_vec);
    exp_t e;
    wait_irq();
    got_vec = irq_vector;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: irq with vector %h but no service expected", irq_vector);
    end else begin
      e = sb.pop_front();
      check("irq_vector", irq_vector, e.vec);
      finish_service(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    exp_t        e;

    reset      = 1'b1;
    int_req    = '0;
    cpu_ack    = 1'b0;
    eoi        = 1'b0;
    mask_we    = 1'b0;
    mask_wdata = '0;

    tbl[0] = '{req: 4'b0100, first_vec: 32'h0000_0108, n_serve: 1};
    tbl[1] = '{req: 4'b1010, first_vec: 32'h0000_0104, n_serve: 2};
    tbl[2] = '{req: 4'b1111, first_vec: 32'h0000_0100, n_serve: 4};
    tbl[3] = '{req: 4'b1000, first_vec: 32'h0000_010C, n_serve: 1};
    tbl[4] = '{req: 4'b0011, first_vec: 32'h0000_0100, n_serve: 2};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_vector", irq_vector, 32'd0);
    check("rst_addr", access_addr, 32'd0);
    check("rst_active_id", {28'b0, active_id}, 32'd0);

    // Idle hold; stray cpu_ack/eoi pulses must be ignored.
    for (int c = 0; c < 10; c++) begin
      cpu_ack = (c == 3);
      eoi     = (c == 5);
      @(negedge clock);
      check("idle_irq", {31'b0, irq}, 32'd0);
      check("idle_addr", access_addr, 32'd0);
    end
    cpu_ack = 1'b0;
    eoi     = 1'b0;

    // Request-to-irq latency of three clocks.
    int_req[2] = 1'b1;
    push_pattern(4'b0100);
    @(negedge clock);
    check("lat1", {31'b0, irq}, 32'd0);
    @(negedge clock);
    check("lat2", {31'b0, irq}, 32'd0);
    @(negedge clock);
    check("lat3", {31'b0, irq}, 32'd1);
    serve_one(v);

    // Priority table: every set bit is served once, lowest index first.
    for (int k = 0; k < 5; k++) begin
      int_req = tbl[k].req;
      push_pattern(tbl[k].req);
      for (int j = 0; j < int'(tbl[k].n_serve); j++) begin
        serve_one(v);
        if (j == 0) check("first_vec", v, tbl[k].first_vec);
      end
      check("sb_empty", 32'(sb.size()), 32'd0);
    end

    // Higher-priority arrival while pending does not preempt.
    int_req[3] = 1'b1;
    wait_irq();
    check("np_vec", irq_vector, 32'h0000_010C);
    int_req[0] = 1'b1;
    repeat (4) @(negedge clock);
    check("np_vec_held", irq_vector, 32'h0000_010C);
    check("np_irq_held", {31'b0, irq}, 32'd1);
    finish_service(mk(3));
    sb.push_back(mk(0));
    serve_one(v);

    // eoi in PEND ignored; cpu_ack+eoi together honours only cpu_ack.
    int_req[2] = 1'b1;
    wait_irq();
    eoi = 1'b1;
    @(negedge clock);
    eoi = 1'b0;
    @(negedge clock);
    check("eoi_in_pend", {31'b0, irq}, 32'd1);
    cpu_ack = 1'b1;
    eoi     = 1'b1;
    @(negedge clock);
    cpu_ack = 1'b0;
    eoi     = 1'b0;
    check("both_ack_addr", access_addr, 32'h0000_0408);
    int_req[2] = 1'b0;
    @(negedge clock);
    check("both_addr_idle", access_addr, 32'd0);
    int_req[0] = 1'b1;
    repeat (6) @(negedge clock);
    check("service_wait", {31'b0, irq}, 32'd0);
    eoi = 1'b1;
    @(negedge clock);
    eoi = 1'b0;
    sb.push_back(mk(0));
    serve_one(v);

    // Asynchronous reset during ACK.
    int_req[1] = 1'b1;
    wait_irq();
    cpu_ack = 1'b1;
    @(negedge clock);
    cpu_ack = 1'b0;
    check("rack_addr", access_addr, 32'h0000_0404);
    reset = 1'b1;
    #1;
    check("rack_addr_clr", access_addr, 32'd0);
    check("rack_irq_clr", {31'b0, irq}, 32'd0);
    check("rack_id_clr", {28'b0, active_id}, 32'd0);
    int_req = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("post_rst_irq", {31'b0, irq}, 32'd0);
    check("post_rst_addr", access_addr, 32'd0);

`ifdef IRQ_DISPATCHER_MASK_EN
    mask_we    = 1'b1;
    mask_wdata = 4'b0001;
    @(negedge clock);
    mask_we    = 1'b0;
    int_req[0] = 1'b1;
    repeat (6) @(negedge clock);
    check("masked_irq", {31'b0, irq}, 32'd0);
    mask_we    = 1'b1;
    mask_wdata = 4'b0000;
    @(negedge clock);
    mask_we = 1'b0;
    @(negedge clock);
    check("unmask_irq", {31'b0, irq}, 32'd1);
    check("unmask_vec", irq_vector, 32'h0000_0100);
    e = mk(0);
    finish_service(e);
`else
    e = mk(0);
    mask_we    = 1'b1;
    mask_wdata = 4'b1111;
    @(negedge clock);
    mask_we    = 1'b0;
    int_req[0] = 1'b1;
    wait_irq();
    check("nomask_vec", irq_vector, e.vec);
    finish_service(e);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
